// File: rtl/pipelined_addsub.sv
// Chunked, pipelined adder/subtractor: CHUNK bits of the sum are resolved per
// stage, with the ripple carry registered between stages.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf,
  output logic             out_valid,
  output logic             busy
);

  localparam bit CFG_BAD = (WIDTH <= 0) || (CHUNK <= 0) ||
                           ((WIDTH % ((CHUNK > 0) ? CHUNK : 1)) != 0);
  localparam int STAGES = (CFG_BAD) ? 1 : WIDTH / CHUNK;
  localparam int unsigned LAST = STAGES - 1;

  if (CFG_BAD) begin : g_cfg_check
    $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  // Stage k holds the full operands, the low k*CHUNK sum bits already
  // resolved, and the carry into chunk k.
  logic [WIDTH-1:0]  a_q       [STAGES];
  logic [WIDTH-1:0]  b_q       [STAGES];
  logic [WIDTH-1:0]  s_q       [STAGES];
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] valid_q;

  logic [CHUNK:0]    chunk_sum [STAGES];
  logic [WIDTH-1:0]  s_next    [STAGES];

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      chunk_sum[k] = {1'b0, a_q[k][k*CHUNK +: CHUNK]}
                   + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_q[k]};
      s_next[k] = s_q[k];
      s_next[k][k*CHUNK +: CHUNK] = chunk_sum[k][CHUNK-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      carry_q   <= '0;
      valid_q   <= '0;
      s         <= '0;
      c         <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      // Subtraction folds into addition: a + ~b + ~cin == a - b - cin.
      a_q[0]     <= a;
      b_q[0]     <= sub ? ~b : b;
      s_q[0]     <= '0;
      carry_q[0] <= cin ^ sub;
      valid_q[0] <= in_valid;
      for (int unsigned k = 0; k + 1 < STAGES; k++) begin
        a_q[k+1]     <= a_q[k];
        b_q[k+1]     <= b_q[k];
        s_q[k+1]     <= s_next[k];
        carry_q[k+1] <= chunk_sum[k][CHUNK];
        valid_q[k+1] <= valid_q[k];
      end
      out_valid <= valid_q[LAST];
      // Result registers only load on a real operation, so they hold across bubbles.
      if (valid_q[LAST]) begin
        s   <= s_next[LAST];
        c   <= chunk_sum[LAST][CHUNK];
        ovf <= (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
               (s_next[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
      end
    end
  end

  assign busy = (|valid_q) | out_valid;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Randomised and directed scoreboard bench for pipelined_addsub (WIDTH=8, CHUNK=4).
module tb_pipelined_addsub;

  localparam int W      = 8;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         rst, en, in_valid, cin, sub;
  logic [W-1:0] a, b;
  logic [W-1:0] s;
  logic         c, ovf, out_valid, busy;

  pipelined_addsub #(.WIDTH(W), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a), .b(b),
    .cin(cin), .sub(sub), .s(s), .c(c), .ovf(ovf), .out_valid(out_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         ovf;
    int           issue;
  } exp_t;

  exp_t q[$];
  int   edge_n   = 0;
  bit   last_en  = 1'b0;
  bit   last_rst = 1'b0;
  bit   started  = 1'b0;
  int   n_vec    = 0;
  int   n_bad    = 0;

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic ci, input logic sb, input int iss);
    exp_t e;
    int   u, sa, sbv, r;
    sa  = int'($signed(aa));
    sbv = int'($signed(bb));
    if (sb) begin
      u     = int'(aa) - int'(bb) - int'(ci);
      r     = sa - sbv - int'(ci);
      e.c   = (u >= 0);
    end else begin
      u     = int'(aa) + int'(bb) + int'(ci);
      r     = sa + sbv + int'(ci);
      e.c   = (u > 255);
    end
    e.s     = u[W-1:0];
    e.ovf   = (r > 127) || (r < -128);
    e.issue = iss;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic r, input logic iv,
                      input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic ci, input logic sb);
    en = e; rst = r; in_valid = iv; a = aa; b = bb; cin = ci; sub = sb;
    @(posedge clk);
    last_en  = e;
    last_rst = r;
    if (!r) q.delete();
    else if (e) begin
      edge_n++;
      if (iv) q.push_back(model(aa, bb, ci, sb, edge_n));
    end
    started = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                    input logic ci, input logic sb);
    step(1'b1, 1'b1, 1'b1, aa, bb, ci, sb);
  endtask

  // Monitor: expected output state derived from the scoreboard queue.
  logic [W-1:0] h_s   = '0;
  logic         h_c   = 1'b0;
  logic         h_ovf = 1'b0;
  logic         exp_v = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      if (!last_rst) begin
        exp_v = 1'b0; h_s = '0; h_c = 1'b0; h_ovf = 1'b0;
      end else if (last_en) begin
        if (q.size() != 0 && q[0].issue + STAGES == edge_n) begin
          exp_t e;
          e = q.pop_front();
          exp_v = 1'b1; h_s = e.s; h_c = e.c; h_ovf = e.ovf;
        end else begin
          exp_v = 1'b0;
        end
      end
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      chk("s",         32'(s),         32'(h_s));
      chk("c",         32'(c),         32'(h_c));
      chk("ovf",       32'(ovf),       32'(h_ovf));
      chk("busy",      32'(busy),      32'(exp_v || (q.size() != 0)));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    // Reset with en low and in_valid high: must still clear and ignore the op.
    step(1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    idle(2);

    // Carry out, signed overflow, subtract overflow, borrow cases.
    op(8'hFF, 8'h01, 1'b0, 1'b0); idle(4);
    op(8'h7F, 8'h01, 1'b0, 1'b0);
    op(8'h80, 8'h01, 1'b0, 1'b1);
    op(8'h05, 8'h07, 1'b0, 1'b1);
    op(8'h05, 8'h07, 1'b1, 1'b1);
    idle(4);

    // Streaming with a bubble after the second op.
    op(8'h10, 8'h20, 1'b0, 1'b0);
    op(8'h30, 8'h40, 1'b1, 1'b0);
    idle(1);
    op(8'hA0, 8'h0F, 1'b0, 1'b1);
    op(8'h01, 8'hFF, 1'b1, 1'b0);
    op(8'h55, 8'hAA, 1'b0, 1'b1);
    idle(5);

    // Stall with three ops in flight; in_valid asserted while stalled is ignored.
    op(8'h11, 8'h22, 1'b0, 1'b0);
    op(8'h33, 8'h44, 1'b0, 1'b1);
    op(8'hF0, 8'h0F, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 8'hEE, 8'hEE, 1'b1, 1'b1);
    idle(5);

    // Reset mid-flight: nothing stale may emerge afterwards.
    op(8'h01, 8'h02, 1'b0, 1'b0);
    op(8'h03, 8'h04, 1'b0, 1'b0);
    op(8'h05, 8'h06, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h07, 8'h08, 1'b0, 1'b0);
    idle(5);

    // Random traffic with occasional stalls and resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 59) != 0),
           ($urandom_range(0, 9) < 7), W'($urandom), W'($urandom),
           1'($urandom), 1'($urandom));
    end
    idle(8);

    chk("drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, meaning bits added per pipeline stage.
REQ-003 SHALL treat a configuration where WIDTH is not a positive multiple of CHUNK as illegal, with an elaboration-time error. STAGES = WIDTH/CHUNK.
REQ-004 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port en  input  1  pipeline advance; 0 freezes every register.
REQ-007 SHALL have port in_valid  input  1  a/b/cin/sub carry a new operation this cycle.
REQ-008 SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-011 SHALL have port sub  input  1  mode select: 0 = add, 1 = subtract.
REQ-012 SHALL have port s  output  WIDTH  result.
REQ-013 SHALL have port c  output  1  raw carry-out of the MSB; in subtract mode, 1 means no borrow.
REQ-014 SHALL have port ovf  output  1  two's-complement overflow flag.
REQ-015 SHALL have port out_valid  output  1  s/c/ovf hold a completed operation.
REQ-016 SHALL have port busy  output  1  OR of the valid bits of all internal stages and out_valid.

Function
REQ-017 SHALL compute s/c as follows: add gives {c,s} = a + b + cin; subtract gives {c,s} = a + ~b + ~cin, i.e. a - b - cin.
REQ-018 SHALL capture a, the effective b (b or ~b), the effective carry (cin or ~cin), and in_valid into an input register on an edge with en=1.
REQ-019 SHALL add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) combinationally after stage-k register, for k = 0..STAGES-1, using the carry registered from chunk k-1.
REQ-020 SHALL register the result of each chunk add into stage k+1 together with the completed low sum bits, the not-yet-added high operand bits, the carry, and the valid bit; stage STAGES is the output register.
REQ-021 SHALL have latency of exactly STAGES+1 enabled edges: inputs sampled on enabled edge N appear on the outputs after enabled edge N+STAGES.
REQ-022 SHALL accept one operation per enabled cycle with no bubbles required (throughput 1/cycle).
REQ-023 SHALL compute ovf = (a_msb == b_eff_msb) && (s_msb != a_msb), registered alongside s.
REQ-024 SHALL give each stage a valid bit that shifts with the data; in_valid=0 inserts a bubble.
REQ-025 SHALL hold s, c and ovf at the last operation's values while out_valid=0, except after reset.
REQ-026 SHALL, while en=0, hold all stage registers, out_valid and busy; in_valid is ignored and no operation is lost or duplicated.
REQ-027 SHALL, with CHUNK=WIDTH (STAGES=1), behave as a two-register adder with latency 2.
REQ-028 SHALL have no combinational path from any input to any output.

Reset
REQ-029 SHALL, on rst=0 at a rising edge, clear every stage register, s, c, ovf, out_valid and busy to 0, regardless of en.
REQ-030 SHALL discard all in-flight operations on reset; the first output after reset comes only from an operation sampled after rst returns high.
REQ-031 SHALL ignore in_valid on the edge at which rst=0.

Verification (WIDTH=8, CHUNK=4, STAGES=2, latency 3 edges)
REQ-032 SHALL pass add with carry: a=0xFF, b=0x01, cin=0, sub=0 -> s=0x00, c=1, ovf=0, out_valid=1 exactly 3 edges after sampling.
REQ-033 SHALL pass signed overflow: a=0x7F, b=0x01, cin=0, sub=0 -> s=0x80, c=0, ovf=1; and sub with a=0x80, b=0x01, cin=0 -> s=0x7F, c=1, ovf=1.
REQ-034 SHALL pass borrow: sub=1, a=0x05, b=0x07, cin=0 -> s=0xFE, c=0, ovf=0; same with cin=1 -> s=0xFD, c=0.
REQ-035 SHALL pass streaming: 5 back-to-back valid ops, with a bubble (in_valid=0) after the 2nd -> outputs in order on consecutive edges with matching out_valid gap; busy drops 3 edges after the last op.
REQ-036 SHALL pass stall: en=0 for 4 cycles while 3 ops are in flight -> outputs and out_valid frozen; on en=1, results resume in order with none lost or repeated.
REQ-037 SHALL pass reset mid-operation: rst=0 for 1 edge with 3 ops in flight -> out_valid=0, busy=0, s=0x00, c=0, ovf=0 next cycle; no stale result ever emerges.
